mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the write-back stage. Consumes the registered EX/MEM fields (ALU result, rd, MemRead/MemWrite/MemtoReg/RegWrite, forwarded rt data) and drives a variable-latency data-memory port with a req/ack handshake. It stalls upstream while an access is outstanding, aborts hung or misaligned accesses, and registers the results into the MEM/WB fields consumed by write-back.

---
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a variable-latency req/ack data-memory port,
// stalls upstream while an access is outstanding, and registers the MEM/WB fields.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aluresult,
  input  logic [4:0]  rd,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] mem_forwarded_rtdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] wb_aluresult,
  output logic [31:0] wb_memdata,
  output logic [4:0]  wb_rd,
  output logic        wb_MemtoReg,
  output logic        wb_RegWrite,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      stateQ, stateD;
  logic [7:0]  cntQ, cntD;
  logic        access, misaligned, isWait, reqRaw, complete, abort, stallRaw, misalignHit;

  logic [31:0] wbAluD, wbMemD;
  logic [4:0]  wbRdD;
  logic        wbM2rD, wbRwD, misErrD, busErrD;

  // Handshake decode; request and stall are gated off while reset is asserted.
  always_comb begin
    access      = MemRead | MemWrite;
    misaligned  = access & (aluresult[1:0] != 2'b00);
    isWait      = (stateQ == WAIT);
    misalignHit = misaligned & ~isWait;
    reqRaw      = (~isWait & access & ~misaligned) | isWait;
    complete    = reqRaw & dmem_ack;
    abort       = isWait & ~dmem_ack & (cntQ == TIMEOUT_LAST);
    stallRaw    = reqRaw & ~dmem_ack & ~abort;
    dmem_req    = reqRaw & rst_n;
    mem_stall   = stallRaw & rst_n;
    dmem_we     = MemWrite & ~MemRead;
    dmem_addr   = aluresult;
    dmem_wdata  = mem_forwarded_rtdata;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      IDLE: begin
        if (reqRaw & ~dmem_ack) begin
          stateD = WAIT;
          cntD   = 8'd0;
        end else begin
          stateD = IDLE;
          cntD   = cntQ;
        end
      end
      WAIT: begin
        if (dmem_ack | abort) begin
          stateD = IDLE;
          cntD   = 8'd0;
        end else begin
          stateD = WAIT;
          cntD   = cntQ + 8'd1;
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = 8'd0;
      end
    endcase
  end

  // MEM/WB next values: faulted accesses retire with RegWrite suppressed, stalls insert a bubble.
  always_comb begin
    wbAluD  = wb_aluresult;
    wbMemD  = wb_memdata;
    wbRdD   = wb_rd;
    wbM2rD  = wb_MemtoReg;
    wbRwD   = wb_RegWrite;
    misErrD = 1'b0;
    busErrD = 1'b0;
    if (misalignHit) begin
      wbAluD  = aluresult;
      wbRdD   = rd;
      wbM2rD  = MemtoReg;
      wbRwD   = 1'b0;
      misErrD = 1'b1;
    end else if (complete) begin
      wbAluD = aluresult;
      wbRdD  = rd;
      wbM2rD = MemtoReg;
      wbRwD  = RegWrite;
      if (MemRead) begin
        wbMemD = dmem_rdata;
      end else begin
        wbMemD = wb_memdata;
      end
    end else if (abort) begin
      wbAluD  = aluresult;
      wbRdD   = rd;
      wbM2rD  = MemtoReg;
      wbRwD   = 1'b0;
      busErrD = 1'b1;
    end else if (stallRaw) begin
      wbRdD  = 5'd0;
      wbM2rD = 1'b0;
      wbRwD  = 1'b0;
    end else begin
      wbAluD = aluresult;
      wbRdD  = rd;
      wbM2rD = MemtoReg;
      wbRwD  = RegWrite;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      cntQ   <= 8'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // MEM/WB pipeline register and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_aluresult <= 32'd0;
      wb_memdata   <= 32'd0;
      wb_rd        <= 5'd0;
      wb_MemtoReg  <= 1'b0;
      wb_RegWrite  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_aluresult <= wbAluD;
      wb_memdata   <= wbMemD;
      wb_rd        <= wbRdD;
      wb_MemtoReg  <= wbM2rD;
      wb_RegWrite  <= wbRwD;
      misalign_err <= misErrD;
      bus_err      <= busErrD;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues expected MEM/WB records per instruction,
// a negedge monitor pops and compares them when an instruction retires.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aluresult, mem_forwarded_rtdata, dmem_rdata;
  logic [4:0]  rd;
  logic        MemRead, MemWrite, MemtoReg, RegWrite, dmem_ack;
  logic        dmem_req, dmem_we, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, wb_aluresult, wb_memdata;
  logic [4:0]  wb_rd;
  logic        wb_MemtoReg, wb_RegWrite, misalign_err, bus_err;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .aluresult(aluresult), .rd(rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .mem_forwarded_rtdata(mem_forwarded_rtdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .wb_aluresult(wb_aluresult), .wb_memdata(wb_memdata), .wb_rd(wb_rd),
    .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        mis;
    logic        bus;
  } wbExp_t;

  wbExp_t      expQ[$];
  int          nVec = 0;
  int          nMiss = 0;
  logic        drvActive = 1'b0;
  logic [31:0] expMemdata = 32'd0;

  task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
    nVec++;
    if (!ok) begin
      nMiss++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compares the MEM/WB record one cycle after each retirement, and bubbles after stalls.
  initial begin
    logic   retired = 1'b0;
    logic   stalledPrev = 1'b0;
    wbExp_t e;
    forever begin
      @(negedge clk);
      if (retired && rst_n) begin
        nVec++;
        if (expQ.size() == 0) begin
          nMiss++;
          $display("FAIL wb_unexpected: retirement with empty scoreboard, wb_rd=%0d", wb_rd);
        end else begin
          e = expQ.pop_front();
          if (wb_aluresult !== e.alu || wb_memdata !== e.mem || wb_rd !== e.rd ||
              wb_MemtoReg !== e.m2r || wb_RegWrite !== e.rw || misalign_err !== e.mis || bus_err !== e.bus) begin
            nMiss++;
            $display("FAIL %s_wb: got alu=%h mem=%h rd=%0d m2r=%b rw=%b mis=%b bus=%b want alu=%h mem=%h rd=%0d m2r=%b rw=%b mis=%b bus=%b",
                     e.name, wb_aluresult, wb_memdata, wb_rd, wb_MemtoReg, wb_RegWrite, misalign_err, bus_err,
                     e.alu, e.mem, e.rd, e.m2r, e.rw, e.mis, e.bus);
          end
        end
      end
      if (stalledPrev && rst_n) begin
        check("stall_bubble", wb_RegWrite === 1'b0 && wb_rd === 5'd0 && wb_MemtoReg === 1'b0 &&
              misalign_err === 1'b0 && bus_err === 1'b0,
              {wb_RegWrite, wb_MemtoReg, wb_rd}, 64'd0);
      end
      retired     = rst_n && !mem_stall && drvActive;
      stalledPrev = rst_n && mem_stall;
    end
  end

  task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rdI, input logic rdB, input logic wrB, input logic m2r,
                       input logic rw, input int ackAt, input logic [31:0] rdata,
                       input int expStall, input int expReq, input logic expMis, input logic expBus);
    wbExp_t e;
    int     nStall = 0;
    int     nReq = 0;
    logic   portBad = 1'b0;
    logic   expWe;
    @(posedge clk); #1;
    aluresult = addr; mem_forwarded_rtdata = wdata; rd = rdI;
    MemRead = rdB; MemWrite = wrB; MemtoReg = m2r; RegWrite = rw;
    dmem_ack = (ackAt == 0); dmem_rdata = rdata; drvActive = 1'b1;
    expWe = wrB & ~rdB;
    if (rdB && !expMis && !expBus) expMemdata = rdata;
    e.name = name; e.alu = addr; e.mem = expMemdata; e.rd = rdI; e.m2r = m2r;
    e.rw = rw & ~expMis & ~expBus; e.mis = expMis; e.bus = expBus;
    expQ.push_back(e);
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        dmem_ack = (k == ackAt);
      end
      @(negedge clk);
      if (dmem_req) begin
        nReq++;
        if (dmem_we !== expWe || dmem_addr !== addr || dmem_wdata !== wdata) portBad = 1'b1;
      end
      if (mem_stall) nStall++;
      else break;
    end
    check({name, "_stall_cycles"}, nStall == expStall, 64'(nStall), 64'(expStall));
    check({name, "_req_cycles"}, nReq == expReq, 64'(nReq), 64'(expReq));
    if (expReq > 0) check({name, "_port_stable"}, !portBad, {63'd0, portBad}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    aluresult = 32'd0; mem_forwarded_rtdata = 32'd0; rd = 5'd0;
    MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", wb_aluresult === 32'd0 && wb_memdata === 32'd0 && wb_rd === 5'd0 &&
          wb_MemtoReg === 1'b0 && wb_RegWrite === 1'b0 && misalign_err === 1'b0 &&
          bus_err === 1'b0 && dmem_req === 1'b0 && mem_stall === 1'b0,
          {wb_aluresult, wb_rd, wb_RegWrite, dmem_req, mem_stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //     name        addr           wdata          rd     rdB   wrB   m2r   rw   ack rdata          stl req mis   bus
    issue("zw_load",   32'h0000_0100, 32'h0,         5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 0, 32'hDEAD_BEEF, 0, 1, 1'b0, 1'b0);
    issue("store3",    32'h0000_0200, 32'h1234_5678, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0,         3, 4, 1'b0, 1'b0);
    issue("rd_wr_ld",  32'h0000_0108, 32'hCAFE_F00D, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1, 32'h0BAD_F00D, 1, 2, 1'b0, 1'b0);
    issue("timeout",   32'h0000_0300, 32'h0,         5'd9,  1'b1, 1'b0, 1'b1, 1'b1, -1, 32'h0,        4, 5, 1'b0, 1'b1);
    issue("alu_op1",   32'h0000_0042, 32'h0,         5'd3,  1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0,        0, 0, 1'b0, 1'b0);
    issue("mis_load",  32'h0000_0102, 32'h0,         5'd4,  1'b1, 1'b0, 1'b1, 1'b1, -1, 32'h0,        0, 0, 1'b1, 1'b0);
    issue("alu_op2",   32'h0000_0777, 32'h0,         5'd7,  1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0,        0, 0, 1'b0, 1'b0);
    issue("mis_store", 32'h0000_0201, 32'h5555_AAAA, 5'd6,  1'b0, 1'b1, 1'b0, 1'b1, -1, 32'h0,        0, 0, 1'b1, 1'b0);
    issue("ack_at_to", 32'h0000_0104, 32'h0,         5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 4, 32'hA5A5_A5A5, 4, 5, 1'b0, 1'b0);
    issue("zw_store",  32'h0000_0010, 32'h0F0F_0F0F, 5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 0, 1, 1'b0, 1'b0);

    // Reset pulsed in the second WAIT cycle of an outstanding load.
    @(posedge clk); #1;
    aluresult = 32'h0000_0400; rd = 5'd11; MemRead = 1'b1; MemWrite = 1'b0;
    MemtoReg = 1'b1; RegWrite = 1'b1; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_stall", dmem_req === 1'b0 && mem_stall === 1'b0, {dmem_req, mem_stall}, 64'd0);
    check("rst_mid_wb", wb_aluresult === 32'd0 && wb_memdata === 32'd0 && wb_rd === 5'd0 &&
          wb_MemtoReg === 1'b0 && wb_RegWrite === 1'b0 && misalign_err === 1'b0 && bus_err === 1'b0,
          {wb_aluresult, wb_rd, wb_RegWrite}, 64'd0);
    drvActive = 1'b0;
    expQ.delete();
    expMemdata = 32'd0;
    aluresult = 32'h0000_0055; rd = 5'd0; MemRead = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("late_ack_no_req", dmem_req === 1'b0 && mem_stall === 1'b0 && wb_RegWrite === 1'b0,
          {dmem_req, mem_stall, wb_RegWrite}, 64'd0);
    issue("post_rst_nop", 32'h0000_0055, 32'h0,      5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h7777_7777, 0, 0, 1'b0, 1'b0);
    issue("post_rst_ld",  32'h0000_0500, 32'h0,      5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 2, 32'h1357_9BDF, 2, 3, 1'b0, 1'b0);

    @(posedge clk); #1;
    drvActive = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", expQ.size() == 0, 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
